// File: rtl/coin_pickup_scheduler_if.sv
// Coin table lookup and pickup report bundle between the coin scheduler,
// the coin position table and the sprite renderer.
interface coin_pickup_scheduler_if;
    logic [3:0] coin_idx;
    logic [9:0] coin_col;
    logic [9:0] coin_row;
    logic       pick_valid;
    logic [3:0] pick_idx;

    modport master (
        output coin_idx,
        output pick_valid,
        output pick_idx,
        input  coin_col,
        input  coin_row
    );

    modport slave (
        input  coin_idx,
        input  pick_valid,
        input  pick_idx,
        output coin_col,
        output coin_row
    );
endinterface

// File: rtl/coin_pickup_scheduler.sv
// Per-frame coin scan: one shared table lookup and overlap test per cycle,
// latching pickups, counting them and stepping the coin animation.
module coin_pickup_scheduler #(
    parameter int NUM_COINS = 10,
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 24,
    parameter int OFF_X     = 25,
    parameter int OFF_Y     = 7
) (
    input  logic                 Clk,
    input  logic                 RESET_n,
    input  logic                 frame_clk,
    input  logic                 restart,
    input  logic [9:0]           BallX0,
    input  logic [9:0]           BallY0,
    input  logic [9:0]           BallX1,
    input  logic [9:0]           BallY1,
    input  logic [9:0]           Collision_h,
    coin_pickup_scheduler_if.master bus,
    output logic [NUM_COINS-1:0] taken,
    output logic [3:0]           taken_count,
    output logic                 all_taken,
    output logic [2:0]           anim_frame,
    output logic                 scan_busy
);

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SCAN,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(NUM_COINS - 1);
    localparam logic [3:0] FULL = 4'(NUM_COINS);

    localparam logic signed [11:0] OX = 12'(OFF_X);
    localparam logic signed [11:0] OY = 12'(OFF_Y);
    localparam logic signed [11:0] SW = 12'(SPRITE_W);
    localparam logic signed [11:0] SH = 12'(SPRITE_H);

    state_t     state;
    logic       fc_s1;
    logic       fc_s2;
    logic       fc_s3;
    logic       tick;
    logic       pending;
    logic [9:0] sx0;
    logic [9:0] sy0;
    logic [9:0] sx1;
    logic [9:0] sy1;
    logic [9:0] sch;
    logic [5:0] anim_cnt;
    logic       hit;
    logic       newly;

    // 12-bit signed so cy - h and cx + w never wrap
    function automatic logic overlap(
        input logic [9:0] bx,
        input logic [9:0] by,
        input logic [9:0] ch,
        input logic [9:0] col,
        input logic [9:0] row
    );
        logic signed [11:0] cx;
        logic signed [11:0] cy;
        logic signed [11:0] px;
        logic signed [11:0] py;
        logic signed [11:0] h;
        cx = $signed({2'b00, col}) <<< 4;
        cy = $signed({2'b00, row}) <<< 4;
        px = $signed({2'b00, bx}) + OX;
        py = $signed({2'b00, by}) + OY;
        h  = $signed({2'b00, ch});
        return (px > cx) && (px < cx + SW) &&
               (py > cy - h) && (py < cy + SH);
    endfunction

    function automatic logic [2:0] frame_of(input logic [5:0] c);
        return (c[5:3] < 3'd3) ? 3'd0 : c[5:3] - 3'd2;
    endfunction

    assign hit = overlap(sx0, sy0, sch, bus.coin_col, bus.coin_row) |
                 overlap(sx1, sy1, sch, bus.coin_col, bus.coin_row);

    assign newly = (state == SCAN) && hit && !taken[bus.coin_idx];

    // frame_clk is asynchronous: two sync flops, then an edge register
    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            fc_s1 <= 1'b0;
            fc_s2 <= 1'b0;
            fc_s3 <= 1'b0;
            tick  <= 1'b0;
        end else begin
            fc_s1 <= frame_clk;
            fc_s2 <= fc_s1;
            fc_s3 <= fc_s2;
            tick  <= fc_s2 & ~fc_s3;
        end
    end

    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state          <= IDLE;
            bus.coin_idx   <= 4'd0;
            bus.pick_valid <= 1'b0;
            bus.pick_idx   <= 4'd0;
            taken          <= '0;
            taken_count    <= 4'd0;
            all_taken      <= 1'b0;
            anim_cnt       <= 6'd0;
            anim_frame     <= 3'd0;
            pending        <= 1'b0;
            scan_busy      <= 1'b0;
            sx0            <= 10'd0;
            sy0            <= 10'd0;
            sx1            <= 10'd0;
            sy1            <= 10'd0;
            sch            <= 10'd0;
        end else if (restart) begin
            state          <= IDLE;
            bus.coin_idx   <= 4'd0;
            bus.pick_valid <= 1'b0;
            taken          <= '0;
            taken_count    <= 4'd0;
            all_taken      <= 1'b0;
            anim_cnt       <= 6'd0;
            anim_frame     <= 3'd0;
            pending        <= 1'b0;
            scan_busy      <= 1'b0;
        end else begin
            bus.pick_valid <= 1'b0;
            all_taken      <= (taken_count == FULL);
            if (tick && (state != IDLE))
                pending <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (tick || pending) begin
                        state     <= SNAP;
                        pending   <= 1'b0;
                        scan_busy <= 1'b1;
                    end
                end
                SNAP: begin
                    sx0          <= BallX0;
                    sy0          <= BallY0;
                    sx1          <= BallX1;
                    sy1          <= BallY1;
                    sch          <= Collision_h;
                    bus.coin_idx <= 4'd0;
                    state        <= SCAN;
                end
                SCAN: begin
                    if (newly) begin
                        taken[bus.coin_idx] <= 1'b1;
                        taken_count         <= taken_count + 4'd1;
                        bus.pick_valid      <= 1'b1;
                        bus.pick_idx        <= bus.coin_idx;
                    end
                    if (bus.coin_idx == LAST) begin
                        state     <= DONE;
                        scan_busy <= 1'b0;
                    end else begin
                        bus.coin_idx <= bus.coin_idx + 4'd1;
                    end
                end
                DONE: begin
                    anim_cnt     <= anim_cnt + 6'd1;
                    anim_frame   <= frame_of(anim_cnt + 6'd1);
                    bus.coin_idx <= 4'd0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/coin_pickup_scheduler.md
Name: coin_pickup_scheduler

Overview:
- Per-frame controller for the level's coin set: on each frame tick it scans all coins sequentially through one shared coordinate lookup and one overlap checker.
- Latches "taken" flags, counts pickups and flags level completion.
- Drives the coin animation frame index.
- Sits between the player position logic, the coin position table (indexed by coin_idx) and the sprite renderer.

Parameters:
- NUM_COINS, 10, number of coins scanned per frame (1..15)
- SPRITE_W, 32, coin collider width in pixels
- SPRITE_H, 24, coin collider height in pixels
- OFF_X, 25, player collider X offset added to BallX
- OFF_Y, 7, player collider Y offset added to BallY

Ports:
- Clk  in  1  system clock (50 MHz)
- RESET_n  in  1  asynchronous active-low reset
- frame_clk  in  1  vsync-rate frame tick, asynchronous to Clk
- restart  in  1  synchronous level-restart pulse
- BallX0, BallY0, BallX1, BallY1  in  10 each  player 0/1 top-left positions
- Collision_h  in  10  player collider height
- coin_idx  out  4  index presented to the coin position table
- coin_col, coin_row  in  10 each  tile column/row of coin[coin_idx], combinational from table
- taken  out  NUM_COINS  per-coin collected flag
- pick_valid  out  1  one-cycle pulse, a coin was newly collected
- pick_idx  out  4  index of the coin collected, valid with pick_valid
- taken_count  out  4  number of collected coins
- all_taken  out  1  high when taken_count == NUM_COINS
- anim_frame  out  3  coin animation frame 0..5
- scan_busy  out  1  high while in SNAP or SCAN

Behaviour:
- Reset (RESET_n low, async): state=IDLE; coin_idx=0, taken=0, pick_valid=0, pick_idx=0, taken_count=0, all_taken=0, anim counter=0, anim_frame=0, pending=0, synchroniser flops=0.
- Frame tick handling: frame_clk passes through a 2-flop synchroniser plus an edge register. A rising edge gives a one-cycle tick, 3 Clk cycles after the frame_clk edge.
- FSM states: IDLE, SNAP, SCAN, DONE.
  - IDLE: on tick (or pending=1) go to SNAP and clear pending.
  - SNAP: capture BallX0/Y0/X1/Y1 and Collision_h into snapshot registers; coin_idx=0; go to SCAN.
  - SCAN: one coin per cycle, using the current coin_col/coin_row against the snapshot. At coin_idx==NUM_COINS-1 go to DONE; otherwise increment coin_idx.
  - DONE: increment the 6-bit anim counter (wraps 63->0); coin_idx=0; go to IDLE.
- Scan latency: tick to DONE is 1 + NUM_COINS + 1 cycles (12 at default).
- Overlap test, all in 12-bit signed arithmetic so that no term wraps:
  - cx = col<<4, cy = row<<4, px = Bx+OFF_X, py = By+OFF_Y.
  - hit_p = (px > cx) && (px < cx+SPRITE_W) && (py > cy-Collision_h) && (py < cy+SPRITE_H). All inequalities are strict.
  - hit = hit_p0 || hit_p1.
- Pickup: in SCAN, if hit and taken[coin_idx]==0, then on the next edge:
  - set taken[coin_idx];
  - taken_count += 1;
  - pulse pick_valid for one cycle with pick_idx=coin_idx.
  - A hit on an already-taken coin has no effect. At most one pickup per cycle.
- all_taken is a registered compare, updated the cycle after taken_count changes.
- anim_frame is derived from counter[5:3]: 0,1,2 -> 0; 3 -> 1; 4 -> 2; 5 -> 3; 6 -> 4; 7 -> 5.
- Tick arriving while not in IDLE: sets pending (one deep; further ticks are dropped). A pending scan starts from IDLE in the cycle after DONE.
- restart, from any state:
  - next state is IDLE;
  - clears taken, taken_count, all_taken, pending, pick_valid and the anim counter;
  - coin_idx=0.
  - restart has priority over a pickup and a tick in the same cycle.
- Reset mid-scan: async clear to the reset values above; no partial state survives.
- Outputs change only on Clk edges (or async reset); none are combinational.

Test Plan:
- Reset then one frame_clk edge with players far away (BallX0=BallX1=600, BallY0=BallY1=450), default coin table -> scan_busy high for 11 cycles, no pick_valid, taken=0, anim counter=1.
- Coin 3 at col=3,row=10, BallX0=30, BallY0=150, Collision_h=20 (px=55, py=157, inside 48..80 / 140..184) -> pick_valid once with pick_idx=3, taken[3]=1, taken_count=1. The next frame with the same position gives no new pulse.
- Boundary: px exactly = cx (BallX0=23) and px = cx+SPRITE_W (BallX0=55) -> no pickup; BallX0=24 -> pickup.
- Both players overlapping coins 4 and 6 in the same frame -> two pick_valid pulses, pick_idx 4 then 6, in scan order; taken_count=2.
- Collect all 10 coins over several frames -> taken_count=10, all_taken=1 one cycle later. Then a restart pulse coinciding with a pickup cycle -> taken=0, taken_count=0, no pick_valid.
- Second frame_clk edge mid-scan -> second scan starts the cycle after DONE. A third edge during the same scan is dropped. 64 scans -> anim_frame sequence 0,0,0,1,2,3,4,5 per 8-scan step, then wraps.
